// File: rtl/irq_pending_ctrl.sv
// Purpose : latches 4 interrupt request lines into pending bits, masks them,
//           and presents the highest-priority eligible id until acknowledged.
// Latency : 2 edges from the capture edge to valid (capture, then present);
//           the presented id is held until ack, so no retraction is possible.
// Backpressure: the consumer throttles via ack; pending bits accumulate meanwhile.
//
// Capture mode macro: IRQ_EDGE_CAPTURE_EN
//   defined   -> rising-edge capture using a req history register
//   undefined -> level capture (req high at an edge sets pending)
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   req      raw request lines, bit 3 highest priority
//   mask_wr  mask write strobe
//   mask_in  mask write data, 1 = enabled
//   ack      consumer accepts the presented id
//   out      registered id of the presented request
//   valid    out holds a presented, unaccepted request
//   pending  registered pending bits
//   mask     current mask register
module irq_pending_ctrl #(
  parameter logic [3:0] MASK_RST = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mask_wr,
  input  logic [3:0] mask_in,
  input  logic       ack,
  output logic [1:0] out,
  output logic       valid,
  output logic [3:0] pending,
  output logic [3:0] mask
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] capture;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [3:0] pending_nxt;
  logic [1:0] out_nxt;
  logic       valid_nxt;
  logic [1:0] top_idx;

`ifdef IRQ_EDGE_CAPTURE_EN
  // History of req at the previous edge; cleared by reset so a line that is
  // already high on the first edge after reset counts as a rising edge.
  logic [3:0] req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 4'b0000;
    end else begin
      req_q <= req;
    end
  end

  assign capture = req & ~req_q;
`else
  assign capture = req;
`endif

  assign eligible = pending & mask;

  // Highest set eligible bit wins.
  always_comb begin
    top_idx = 2'd0;
    if (eligible[3]) begin
      top_idx = 2'd3;
    end else if (eligible[2]) begin
      top_idx = 2'd2;
    end else if (eligible[1]) begin
      top_idx = 2'd1;
    end else begin
      top_idx = 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    valid_nxt = valid;
    clr       = 4'b0000;
    case (state)
      IDLE: begin
        // ack is deliberately ignored here.
        if (eligible != 4'b0000) begin
          out_nxt   = top_idx;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      PRESENT: begin
        // out stays frozen regardless of new arrivals or mask changes.
        if (ack) begin
          clr       = 4'b0001 << out;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    // Set wins over clear: a fresh capture on the acked bit keeps it pending.
    pending_nxt = (pending & ~clr) | capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 4'b0000;
      mask    <= MASK_RST;
      out     <= 2'b00;
      valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      out     <= out_nxt;
      valid   <= valid_nxt;
      if (mask_wr) begin
        mask <= mask_in;
      end
    end
  end

endmodule
